// File: rtl/mont_pkg.sv
// mont_pkg: shared Montgomery widths and operand-loader state encoding.
// Used by the loader, the multiplier and the hardware-eval wrappers.
package mont_pkg;
    localparam int WORD_W  = 32;
    localparam int OP_W    = 1024;
    localparam int N_WORDS = OP_W / WORD_W;
    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_M, START, WAIT, DRAIN} state_t;
endpackage

// File: rtl/mont_word_reg.sv
// mont_word_reg: OP_W-bit register with word-indexed write/read and a full-width load.
// Ports: clk, resetn (sync, active-low, clears to 0); we/idx/wdata write one word;
// ld/ld_data load the whole register (ld wins over we); q is the full value;
// rdata is the word selected by idx.
module mont_word_reg #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 1024,
    parameter int IW     = (OP_W / WORD_W > 1) ? $clog2(OP_W / WORD_W) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic              ld,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [OP_W-1:0]   ld_data,
    output logic [OP_W-1:0]   q,
    output logic [WORD_W-1:0] rdata
);
    always_ff @(posedge clk)
        if (!resetn)
            q <= '0;
        else if (ld)
            q <= ld_data;
        else if (we)
            q[idx*WORD_W +: WORD_W] <= wdata;

    assign rdata = q[idx*WORD_W +: WORD_W];
endmodule

// File: rtl/mont_operand_loader.sv
// mont_operand_loader: streams A, B, M into the Montgomery multiplier and streams the result out.
// Ports: clk, resetn (sync, active-low); s_valid/s_data/s_ready operand word stream in;
// m_start/m_in_a/m_in_b/m_in_m to the multiplier, m_result/m_done back from it;
// o_valid/o_data/o_last/o_ready result word stream out; busy high unless idle.
// Both streams are least-significant word first.
module mont_operand_loader #(
    parameter int WORD_W = mont_pkg::WORD_W,
    parameter int OP_W   = mont_pkg::OP_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_start,
    output logic [OP_W-1:0]   m_in_a,
    output logic [OP_W-1:0]   m_in_b,
    output logic [OP_W-1:0]   m_in_m,
    input  logic [OP_W-1:0]   m_result,
    input  logic              m_done,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_last,
    input  logic              o_ready,
    output logic              busy
);
    import mont_pkg::*;

    localparam int N  = OP_W / WORD_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t            state, nstate;
    logic [IW-1:0]     wcnt, nwcnt;
    logic              last, we_a, we_b, we_m, ld_r;
    logic [OP_W-1:0]   res_q;
    logic [WORD_W-1:0] a_rd_unused, b_rd_unused, m_rd_unused;

    assign last = wcnt == IW'(N - 1);
    assign busy = !(state == LOAD_A && wcnt == '0);

    always_ff @(posedge clk)
        if (!resetn) begin
            state <= LOAD_A;
            wcnt  <= '0;
        end else begin
            state <= nstate;
            wcnt  <= nwcnt;
        end

    always_comb begin
        nstate  = state;
        nwcnt   = wcnt;
        s_ready = 1'b0;
        m_start = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        we_a    = 1'b0;
        we_b    = 1'b0;
        we_m    = 1'b0;
        ld_r    = 1'b0;
        case (state)
            LOAD_A, LOAD_B, LOAD_M: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    we_a  = state == LOAD_A;
                    we_b  = state == LOAD_B;
                    we_m  = state == LOAD_M;
                    nwcnt = last ? '0 : wcnt + 1'b1;
                    if (last)
                        nstate = state == LOAD_A ? LOAD_B : state == LOAD_B ? LOAD_M : START;
                end
            end
            // m_done is deliberately not looked at here: a pulse in START is dropped.
            START: begin
                m_start = 1'b1;
                nstate  = WAIT;
            end
            WAIT: if (m_done) begin
                ld_r   = 1'b1;
                nstate = DRAIN;
            end
            // wcnt is 0 on entry because the M load wrapped it.
            DRAIN: begin
                o_valid = 1'b1;
                o_last  = last;
                if (o_ready) begin
                    nwcnt = last ? '0 : wcnt + 1'b1;
                    if (last)
                        nstate = LOAD_A;
                end
            end
            default: begin
                nstate = LOAD_A;
                nwcnt  = '0;
            end
        endcase
    end

    mont_word_reg #(.WORD_W(WORD_W), .OP_W(OP_W), .IW(IW)) u_a (
        .clk(clk), .resetn(resetn), .we(we_a), .ld(1'b0), .idx(wcnt), .wdata(s_data),
        .ld_data('0), .q(m_in_a), .rdata(a_rd_unused)
    );

    mont_word_reg #(.WORD_W(WORD_W), .OP_W(OP_W), .IW(IW)) u_b (
        .clk(clk), .resetn(resetn), .we(we_b), .ld(1'b0), .idx(wcnt), .wdata(s_data),
        .ld_data('0), .q(m_in_b), .rdata(b_rd_unused)
    );

    mont_word_reg #(.WORD_W(WORD_W), .OP_W(OP_W), .IW(IW)) u_m (
        .clk(clk), .resetn(resetn), .we(we_m), .ld(1'b0), .idx(wcnt), .wdata(s_data),
        .ld_data('0), .q(m_in_m), .rdata(m_rd_unused)
    );

    mont_word_reg #(.WORD_W(WORD_W), .OP_W(OP_W), .IW(IW)) u_r (
        .clk(clk), .resetn(resetn), .we(1'b0), .ld(ld_r), .idx(wcnt), .wdata('0),
        .ld_data(m_result), .q(res_q), .rdata(o_data)
    );
endmodule

// File: tb/tb_mont_operand_loader.sv
// tb_mont_operand_loader: directed self-checking bench for mont_operand_loader.
module tb_mont_operand_loader;
    localparam int W  = 32;
    localparam int OW = 1024;
    localparam int N  = OW / W;

    logic          clk = 1'b0, resetn = 1'b0, s_valid = 1'b0, m_done = 1'b0, o_ready = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [OW-1:0] m_result = '0;
    logic          s_ready, m_start, o_valid, o_last, busy;
    logic [OW-1:0] m_in_a, m_in_b, m_in_m;
    logic [W-1:0]  o_data;

    logic [OW-1:0] one, tm, m2, a3, b3, r1, r2, junk;
    int errors = 0, checks = 0, starts = 0;

    mont_operand_loader dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_start(m_start), .m_in_a(m_in_a), .m_in_b(m_in_b), .m_in_m(m_in_m),
        .m_result(m_result), .m_done(m_done), .o_valid(o_valid), .o_data(o_data),
        .o_last(o_last), .o_ready(o_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_start) starts++;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        int d = 0;
        checks++;
        for (int i = N - 1; i >= 0; i--) if (obs[i*W +: W] !== exp[i*W +: W]) d = i;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: word %0d got %h expected %h", tag, d, obs[d*W +: W], exp[d*W +: W]);
        end
    endtask

    // Feeds A, B, M word by word with 0..maxgap idle cycles before each word; returns at the
    // falling edge right after the final M word was accepted.
    task automatic load_job(input logic [OW-1:0] a, input logic [OW-1:0] b,
                            input logic [OW-1:0] m, input int maxgap);
        logic [OW-1:0] ops [3];
        ops[0] = a;
        ops[1] = b;
        ops[2] = m;
        for (int o = 0; o < 3; o++)
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, maxgap)) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    @(negedge clk);
                end
                s_valid = 1'b1;
                s_data  = ops[o][i*W +: W];
                @(negedge clk);
            end
        s_valid = 1'b0;
    endtask

    // Drains one result; tog selects the 1,0,0,1 o_ready pattern, otherwise o_ready stays high.
    task automatic drain(input logic [OW-1:0] r, input bit tog, input logic [OW-1:0] mexp);
        int idx = 0, k = 0;
        bit stalled = 1'b0;
        logic [W-1:0] held = '0;
        while (idx < N && k < 300) begin
            o_ready = tog ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            chk("drain_valid", W'(o_valid), 32'd1);
            chkw("drain_m_const", m_in_m, mexp);
            if (stalled) chk("stall_hold", o_data, held);
            if (o_ready) begin
                chk($sformatf("o_data[%0d]", idx), o_data, r[idx*W +: W]);
                chk($sformatf("o_last[%0d]", idx), W'(o_last), W'(idx == N - 1));
                idx++;
                stalled = 1'b0;
            end else begin
                held    = o_data;
                stalled = 1'b1;
            end
            k++;
            @(negedge clk);
        end
        o_ready = 1'b0;
        chk("drain_count", W'(idx), W'(N));
        chk("post_drain_s_ready", W'(s_ready), 32'd1);
        chk("post_drain_busy", W'(busy), 32'd0);
        chk("post_drain_o_valid", W'(o_valid), 32'd0);
    endtask

    initial begin
        one = '0;
        one[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            tm[i*W +: W] = W'(32'h9E3779B9 * (i + 1));
            m2[i*W +: W] = W'(32'h7F4A7C15 * (i + 3)) ^ 32'h0F0F0F0E;
            a3[i*W +: W] = W'(i * 3 + 7);
            b3[i*W +: W] = W'(32'hC0DE0000 + i);
            r1[i*W +: W] = 32'hA5000000 | W'(i * 32'h00010101);
            junk[i*W +: W] = 32'hDEADBEEF;
        end
        tm[0] = 1'b1;
        tm[OW-1] = 1'b1;
        m2[0] = 1'b1;
        r1[W-1:0] = 32'h00000123;
        r2 = m2 ^ a3 ^ b3;

        repeat (2) @(negedge clk);
        chk("rst_s_ready", W'(s_ready), 32'd1);
        chk("rst_m_start", W'(m_start), 32'd0);
        chk("rst_o_valid", W'(o_valid), 32'd0);
        chk("rst_o_last", W'(o_last), 32'd0);
        chk("rst_busy", W'(busy), 32'd0);
        chkw("rst_a", m_in_a, '0);
        chkw("rst_m", m_in_m, '0);
        resetn = 1'b1;

        // Job 1: back-to-back load, discarded m_done in START, result taken in WAIT.
        load_job(one, one, tm, 0);
        chk("j1_start_latency", W'(m_start), 32'd1);
        chkw("j1_a", m_in_a, one);
        chkw("j1_b", m_in_b, one);
        chkw("j1_m", m_in_m, tm);
        chk("j1_start_s_ready", W'(s_ready), 32'd0);
        chk("j1_start_busy", W'(busy), 32'd1);
        m_done = 1'b1;
        m_result = junk;
        s_valid = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        chk("j1_start_once", W'(m_start), 32'd0);
        chk("j1_start_count", W'(starts), 32'd1);
        chk("j1_wait_o_valid", W'(o_valid), 32'd0);
        chk("j1_wait_backpressure", W'(s_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("j1_wait5_o_valid", W'(o_valid), 32'd0);
        chkw("j1_wait_m_const", m_in_m, tm);
        m_done = 1'b1;
        m_result = r1;
        @(negedge clk);
        m_done = 1'b0;
        m_result = junk;
        s_valid = 1'b0;
        chk("j1_first_word", o_data, 32'h00000123);
        drain(r1, 1'b1, tm);

        // Job 2: same operands with random gaps, then abort by reset in WAIT.
        load_job(one, one, tm, 5);
        chk("j2_start_latency", W'(m_start), 32'd1);
        chkw("j2_a_gap", m_in_a, one);
        chkw("j2_b_gap", m_in_b, one);
        chkw("j2_m_gap", m_in_m, tm);
        @(negedge clk);
        chk("j2_start_count", W'(starts), 32'd2);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_done = 1'b1;
        m_result = r1;
        @(negedge clk);
        m_done = 1'b0;
        chk("abort_o_valid", W'(o_valid), 32'd0);
        chk("abort_s_ready", W'(s_ready), 32'd1);
        chk("abort_busy", W'(busy), 32'd0);
        chkw("abort_m_cleared", m_in_m, '0);
        repeat (3) @(negedge clk);
        chk("abort_o_valid_later", W'(o_valid), 32'd0);
        chk("abort_start_count", W'(starts), 32'd2);

        // Job 3: new M, small gaps, free-flowing drain.
        load_job(a3, b3, m2, 1);
        chk("j3_start_latency", W'(m_start), 32'd1);
        chkw("j3_a", m_in_a, a3);
        chkw("j3_b", m_in_b, b3);
        chkw("j3_m", m_in_m, m2);
        repeat (3) @(negedge clk);
        chkw("j3_wait_m_const", m_in_m, m2);
        m_done = 1'b1;
        m_result = r2;
        @(negedge clk);
        m_done = 1'b0;
        drain(r2, 1'b0, m2);
        chk("j3_start_count", W'(starts), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mont_operand_loader.md
MONT_OPERAND_LOADER -- requirements
Module: mont_operand_loader

Interface
REQ-001 Parameter WORD_W, default 32: width of one stream word.
REQ-002 Parameter OP_W, default 1024: width of one Montgomery operand; OP_W SHALL be a multiple of WORD_W.
REQ-003 Port clk  input  1: clock; all logic on the rising edge.
REQ-004 Port resetn  input  1: reset, synchronous, active-low.
REQ-005 Port s_valid  input  1: input word valid.
REQ-006 Port s_data  input  WORD_W: input word.
REQ-007 Port s_ready  output  1: block accepts s_data this cycle.
REQ-008 Port m_start  output  1: one-cycle start pulse to the multiplier.
REQ-009 Port m_in_a, m_in_b, m_in_m  output  OP_W each: operands A, B, modulus M to the multiplier.
REQ-010 Port m_result  input  OP_W: multiplier result.
REQ-011 Port m_done  input  1: multiplier completion, sampled only in state WAIT.
REQ-012 Port o_valid  output  1: output word valid.
REQ-013 Port o_data  output  WORD_W: output result word.
REQ-014 Port o_last  output  1: high with the final output word of a result.
REQ-015 Port o_ready  input  1: downstream accepts o_data.
REQ-016 Port busy  output  1: high in every state except LOAD_A with word count 0.

Function
REQ-017 Handshake: a transfer occurs on any cycle where valid and ready are both high; o_data, o_last and o_valid SHALL hold stable while o_valid is high and o_ready is low.
REQ-018 States: LOAD_A, LOAD_B, LOAD_M, START, WAIT, DRAIN; a word counter wcnt counts 0..N-1, where N = OP_W/WORD_W.
REQ-019 s_ready SHALL be high in LOAD_A, LOAD_B and LOAD_M, and low otherwise.
REQ-020 Load order: words arrive least-significant first; each accepted word lands in bits [wcnt*WORD_W +: WORD_W] of the current operand.
REQ-021 When word N-1 is accepted, wcnt wraps to 0 and the state advances: LOAD_A->LOAD_B->LOAD_M->START.
REQ-022 Stalls (s_valid low) SHALL change neither wcnt nor the state.
REQ-023 START lasts exactly one cycle with m_start high, then moves to WAIT; m_start is low in all other states.
REQ-024 Latency: the final M word accepted in cycle t gives m_start high in cycle t+1.
REQ-025 m_in_a, m_in_b and m_in_m SHALL remain constant from START until the state leaves DRAIN.
REQ-026 m_done is ignored in START (a pulse there is discarded); in WAIT, m_done high latches m_result into the output register and moves to DRAIN on the next cycle.
REQ-027 DRAIN: o_valid is high and o_data = result bits [wcnt*WORD_W +: WORD_W], least-significant first; wcnt increments on each output transfer.
REQ-028 o_last is high when wcnt = N-1.
REQ-029 Transfer of the last word: return to LOAD_A with wcnt = 0, and s_ready high on the next cycle.
REQ-030 Operand registers are not cleared between jobs; each job overwrites every word.
REQ-031 s_valid asserted outside the load states SHALL be back-pressured (s_ready low) with no data loss upstream.

Reset
REQ-032 On resetn low at a clock edge: state = LOAD_A, wcnt = 0, operand and result registers = 0.
REQ-033 Output values while in reset: s_ready = 1, m_start = 0, o_valid = 0, o_last = 0, busy = 0.
REQ-034 Reset in any state, including WAIT or DRAIN mid-operation, SHALL abort the job; a later m_done for the aborted job is ignored because the state is not WAIT.

Structure
REQ-035 Shared package mont_pkg SHALL hold WORD_W, OP_W, N_WORDS and the state encoding, shared with the multiplier and hardware-eval wrappers.
REQ-036 One sub-module, mont_word_reg, SHALL provide an OP_W register with word-indexed write and word-indexed read; it is instantiated for A, B, M and the result.

Verification
REQ-037 Load A = 1, B = 1, M = the 1024-bit test modulus as 96 back-to-back words -> m_start is high exactly one cycle after the 96th word, and m_in_* match the loaded values.
REQ-038 Random s_valid gaps of 0-5 cycles during loading -> operands are identical to the gap-free case, and m_start occurs exactly once.
REQ-039 m_done = 1 during START, then m_done = 1 five cycles into WAIT with m_result = 0x...0123 -> only the second pulse is taken; the first output word is 0x00000123, and o_last is high on word 31 only.
REQ-040 o_ready toggling 1,0,0,1 during DRAIN -> o_data stays stable while stalled; all 32 words are delivered in order with no duplicates, and s_ready rises the cycle after the last transfer.
REQ-041 resetn pulsed low in WAIT, then m_done = 1 -> no o_valid appears, state is LOAD_A, and busy = 0.
REQ-042 Two consecutive jobs with different M -> the second result uses the new M, and m_in_m is constant throughout each job.
